// File: rtl/m_tx_frame_gen_if.sv
// Handshake and data bundle for the transmit frame generator.
// The generator side uses the master modport; the surrounding logic uses slave.
interface m_tx_frame_gen_if;
   logic        tx_start;
   logic [15:0] n_len;
   logic        sts_err;
   logic        sts_srv;
   logic        sts_busy;
   logic [7:0]  pl_d;
   logic        pl_rdy;
   logic        pl_ack;
   logic        ser_busy;
   logic [7:0]  q;
   logic        q_rdy;
   logic [15:0] crc;
   logic        crc_update_disable;
   logic        crc_rst;
   logic        tx_busy;
   logic        tx_frame_end;
   logic        tx_underrun;

   modport master (
      input  tx_start, n_len, sts_err, sts_srv, sts_busy, pl_d, pl_rdy, ser_busy, crc,
      output pl_ack, q, q_rdy, crc_update_disable, crc_rst, tx_busy, tx_frame_end, tx_underrun
   );

   modport slave (
      output tx_start, n_len, sts_err, sts_srv, sts_busy, pl_d, pl_rdy, ser_busy, crc,
      input  pl_ack, q, q_rdy, crc_update_disable, crc_rst, tx_busy, tx_frame_end, tx_underrun
   );
endinterface

// File: rtl/m_tx_frame_gen.sv
// Frame generator: MRK, status, N (2 bytes), N payload bytes, CRC (2 bytes).
// Define TX_PL_TIMEOUT_EN to pad a starved payload slot with 8'h00 after PL_TMO cycles.
module m_tx_frame_gen #(
   parameter logic [7:0] MRK    = 8'h5A,
   parameter int         PL_TMO = 255
) (
   input  logic             clk,
   input  logic             rst,
   m_tx_frame_gen_if.master bus
);
   typedef enum logic [3:0] {
      ST_IDLE, ST_MRK, ST_STS, ST_NH, ST_NL, ST_PL, ST_CRCH, ST_CRCL, ST_END
   } state_t;

   if (PL_TMO < 1 || PL_TMO > 65535) begin : g_tmo_range
      $error("PL_TMO must be in 1..65535");
   end

   state_t      state_q, state_d, next_st;
   logic [15:0] n_q, n_d, cnt_q, cnt_d, crc_lat_q, crc_lat_d;
   logic [2:0]  sts_q, sts_d;
   logic [7:0]  q_q, q_d, byte_v;
   logic        q_rdy_q, q_rdy_d, pl_ack_q, pl_ack_d, busy_q, busy_d;
   logic        fe_q, fe_d, und_q, und_d, cud_q, cud_d, crst_q, crst_d;
   logic        emit, emit_ok;
`ifdef TX_PL_TIMEOUT_EN
   logic [15:0] tmo_q, tmo_d;
`endif

   always_comb begin
      state_d   = state_q;
      next_st   = state_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      sts_d     = sts_q;
      crc_lat_d = crc_lat_q;
      q_d       = q_q;
      q_rdy_d   = 1'b0;
      pl_ack_d  = 1'b0;
      fe_d      = 1'b0;
      und_d     = 1'b0;
      byte_v    = 8'h00;
      emit      = 1'b0;
`ifdef TX_PL_TIMEOUT_EN
      tmo_d     = '0;
`endif
      // A strobe is always followed by a gap cycle, in which the state advances.
      emit_ok = !bus.ser_busy && !q_rdy_q;

      case (state_q)
         ST_IDLE: if (bus.tx_start) begin
            state_d = ST_MRK;
            n_d     = bus.n_len;
            cnt_d   = bus.n_len;
            sts_d   = {bus.sts_busy, bus.sts_srv, bus.sts_err};
         end
         ST_MRK:  begin byte_v = MRK;              emit = emit_ok; next_st = ST_STS; end
         ST_STS:  begin byte_v = {5'b0, sts_q};    emit = emit_ok; next_st = ST_NH;  end
         ST_NH:   begin byte_v = n_q[15:8];        emit = emit_ok; next_st = ST_NL;  end
         ST_NL:   begin
            byte_v  = n_q[7:0];
            emit    = emit_ok;
            next_st = (n_q == 16'd0) ? ST_CRCH : ST_PL;
         end
         ST_PL: begin
            next_st = (cnt_q == 16'd0) ? ST_CRCH : ST_PL;
            byte_v  = bus.pl_d;
            if (emit_ok && bus.pl_rdy) begin
               emit     = 1'b1;
               pl_ack_d = 1'b1;
            end
`ifdef TX_PL_TIMEOUT_EN
            if (q_rdy_q || bus.pl_rdy) begin
               tmo_d = '0;
            end else if (({16'd0, tmo_q} + 32'd1) >= 32'(PL_TMO)) begin
               if (!bus.ser_busy) begin
                  byte_v = 8'h00;
                  emit   = 1'b1;
                  und_d  = 1'b1;
               end else begin
                  tmo_d = tmo_q;
               end
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
`endif
            if (emit) cnt_d = cnt_q - 16'd1;
         end
         ST_CRCH: begin
            // The engine is frozen here, so the live value equals the one latched.
            byte_v  = bus.crc[15:8];
            emit    = emit_ok;
            next_st = ST_CRCL;
            if (emit_ok) crc_lat_d = bus.crc;
         end
         ST_CRCL: begin
            byte_v  = crc_lat_q[7:0];
            emit    = emit_ok;
            fe_d    = emit_ok;
            next_st = ST_END;
         end
         ST_END:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (q_rdy_q && state_q != ST_IDLE && state_q != ST_END) state_d = next_st;
      if (emit) begin
         q_d     = byte_v;
         q_rdy_d = 1'b1;
      end
      busy_d = (state_d != ST_IDLE);
      cud_d  = (state_d inside {ST_CRCH, ST_CRCL, ST_END});
      crst_d = (state_d == ST_END);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         n_q       <= '0;
         cnt_q     <= '0;
         sts_q     <= '0;
         crc_lat_q <= '0;
         q_q       <= '0;
         q_rdy_q   <= 1'b0;
         pl_ack_q  <= 1'b0;
         busy_q    <= 1'b0;
         fe_q      <= 1'b0;
         und_q     <= 1'b0;
         cud_q     <= 1'b0;
         crst_q    <= 1'b0;
`ifdef TX_PL_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         sts_q     <= sts_d;
         crc_lat_q <= crc_lat_d;
         q_q       <= q_d;
         q_rdy_q   <= q_rdy_d;
         pl_ack_q  <= pl_ack_d;
         busy_q    <= busy_d;
         fe_q      <= fe_d;
         und_q     <= und_d;
         cud_q     <= cud_d;
         crst_q    <= crst_d;
`ifdef TX_PL_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign bus.q                  = q_q;
   assign bus.q_rdy              = q_rdy_q;
   assign bus.pl_ack             = pl_ack_q;
   assign bus.tx_busy            = busy_q;
   assign bus.tx_frame_end       = fe_q;
   assign bus.tx_underrun        = und_q;
   assign bus.crc_update_disable = cud_q;
   assign bus.crc_rst            = crst_q;
endmodule

// File: doc/m_tx_frame_gen.md
M_TX_FRAME_GEN -- requirements
Module: m_tx_frame_gen

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter MRK, default 8'h5A (MARKER_SLAVE value from message defs), meaning the marker byte sent first.
REQ-003 SHALL have parameter PL_TMO, default 255, meaning the payload-wait timeout in clk cycles.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 tx_start  in  1  one-cycle frame request, sampled only in IDLE.
REQ-007 n_len  in  16  payload byte count N, latched on accepted tx_start.
REQ-008 sts_err, sts_srv, sts_busy  in  1 each  status bits, latched on accepted tx_start.
REQ-009 pl_d / pl_rdy  in  8 / 1  payload byte and its valid flag.
REQ-010 pl_ack  out  1  one-cycle pulse: pl_d consumed.
REQ-011 ser_busy  in  1  downstream serializer busy.
REQ-012 q / q_rdy  out  8 / 1  emitted byte and one-cycle strobe.
REQ-013 crc  in  16  running CRC from external engine, updated on q_rdy.
REQ-014 crc_update_disable, crc_rst  out  1 each  CRC engine control.
REQ-015 tx_busy, tx_frame_end, tx_underrun  out  1 each  frame active, last-byte pulse, timeout-pad pulse.

Function
REQ-016 Frame order SHALL be: MRK, status {5'b0, sts_busy, sts_srv, sts_err}, N[15:8], N[7:0], N payload bytes, crc[15:8], crc[7:0]; total N+6 bytes.
REQ-017 FSM states SHALL be IDLE, MRK, STS, NH, NL, PL, CRCH, CRCL, END.
REQ-018 tx_start in IDLE SHALL move to MRK next cycle and raise tx_busy; tx_start outside IDLE SHALL be ignored.
REQ-019 Each byte state SHALL emit when ser_busy=0: q set and q_rdy high for exactly one cycle, then advance; ser_busy=1 SHALL hold the state with q_rdy low.
REQ-020 Consecutive q_rdy strobes SHALL be separated by at least one idle cycle.
REQ-021 PL SHALL emit only when pl_rdy=1 and ser_busy=0, pulsing pl_ack in the same cycle as q_rdy; a 16-bit down-counter SHALL track remaining payload.
REQ-022 N=0 SHALL skip PL (NL -> CRCH); N=16'hFFFF SHALL send 65535 bytes without counter wrap.
REQ-023 On CRCH entry, at least one cycle after the last covered q_rdy, crc SHALL be latched once; CRCH and CRCL SHALL send the latched value.
REQ-024 crc_update_disable SHALL be high from CRCH entry through END, low otherwise; CRC covers MRK through last payload byte.
REQ-025 tx_frame_end SHALL pulse one cycle coincident with the CRCL q_rdy; END SHALL last one cycle, then IDLE.
REQ-026 crc_rst SHALL pulse one cycle in END (the cycle after tx_frame_end).
REQ-027 tx_busy SHALL be high from MRK through END.

Reset
REQ-028 rst SHALL asynchronously force IDLE; q=0, q_rdy=0, pl_ack=0, tx_busy=0, tx_frame_end=0, tx_underrun=0, crc_update_disable=0, crc_rst=0; latched N/status/CRC cleared.
REQ-029 rst mid-frame SHALL abort with no further strobes; the next frame requires a new tx_start.

Configuration
REQ-030 With TX_PL_TIMEOUT_EN defined, PL_TMO consecutive PL cycles with pl_rdy=0 SHALL emit 8'h00 as that payload byte (no pl_ack) and pulse tx_underrun with its q_rdy; the timer resets on every emitted byte.
REQ-031 Without TX_PL_TIMEOUT_EN, PL SHALL wait indefinitely for pl_rdy and tx_underrun SHALL be tied 0.

Verification
REQ-032 N=2, status 3'b101, payload 11,22, ser_busy=0, crc model -> q sequence 5A,05,00,02,11,22,crcH,crcL; tx_frame_end on byte 8; crc_rst next cycle.
REQ-033 N=0 -> 6 bytes 5A,sts,00,00,crcH,crcL; pl_ack never pulses.
REQ-034 ser_busy held high 10 cycles during NH -> no q_rdy during hold, byte order unchanged, no duplicates.
REQ-035 tx_start pulsed during PL -> ignored, current frame completes, single tx_frame_end.
REQ-036 rst asserted during PL byte 3 of N=8 -> all outputs 0 immediately; new tx_start sends a complete correct frame.
REQ-037 TX_PL_TIMEOUT_EN, PL_TMO=4, pl_rdy low 4 cycles at payload byte 1 -> q=00, tx_underrun pulse, frame length still N+6.
